// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - IF-stage program counter with prioritised redirects and return-address stack
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]      EXC_VECTOR = 32'h0000_0080,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             flush_o,
  output logic             ras_empty_o,
  output logic             ras_overflow_o,
  output logic             ras_underflow_o
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(STEP - 1);
  localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR) & ALIGN_MASK;
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] pc_plus;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty;
  logic             ras_full;
  logic             redirect;

  assign pc_plus   = pc_q + STEP_W;
  assign top_idx   = wptr_q - PTR_ONE;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == DEPTH_C);

  always_comb begin
    pc_d     = pc_q;
    ras_d    = ras_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    redirect = 1'b0;

    if (exc_i) begin
      pc_d     = EXC_PC;
      count_d  = '0;
      redirect = 1'b1;
    end else if (branch_taken_i) begin
      pc_d     = branch_target_i & ALIGN_MASK;
      redirect = 1'b1;
    end else if (!stall_i) begin
      if (ret_i && !ras_empty) begin
        pc_d     = ras_q[top_idx] & ALIGN_MASK;
        redirect = 1'b1;
        // A call paired with a return replaces the popped entry in place.
        if (jump_i && call_i) begin
          ras_d[top_idx] = pc_plus;
        end else begin
          wptr_d  = top_idx;
          count_d = count_q - CNT_ONE;
        end
      end else begin
        if (ret_i) begin
          unf_d = 1'b1;
        end
        if (jump_i) begin
          pc_d     = jump_target_i & ALIGN_MASK;
          redirect = 1'b1;
          if (call_i) begin
            ras_d[wptr_q] = pc_plus;
            wptr_d        = wptr_q + PTR_ONE;
            if (ras_full) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
        end else begin
          pc_d = pc_plus;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus_o       = pc_plus;
  assign flush_o         = rst_n & redirect;
  assign ras_empty_o     = ras_empty;
  assign ras_overflow_o  = ovf_q;
  assign ras_underflow_o = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, exc_i, branch_taken_i, jump_i, call_i, ret_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] pc_o, pc_plus_o;
  logic        flush_o, ras_empty_o, ras_overflow_o, ras_underflow_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_PC(32'h0), .EXC_VECTOR(32'h0000_0080), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .exc_i(exc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .call_i(call_i), .ret_i(ret_i),
    .pc_o(pc_o), .pc_plus_o(pc_plus_o), .flush_o(flush_o), .ras_empty_o(ras_empty_o),
    .ras_overflow_o(ras_overflow_o), .ras_underflow_o(ras_underflow_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic ex, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                      input logic cl, input logic rt, input logic exp_flush,
                      input logic [31:0] exp_pc);
    logic [31:0] want;
    stall_i = st; exc_i = ex; branch_taken_i = br; branch_target_i = bt;
    jump_i = jp; jump_target_i = jt; call_i = cl; ret_i = rt;
    #1;
    check({tag, ".flush"}, {31'b0, flush_o}, {31'b0, exp_flush});
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      want = exp_q.pop_front();
      check({tag, ".pc"}, pc_o, want);
    end
  endtask

  task automatic seq(input string tag, input logic [31:0] exp_pc);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, exp_pc);
  endtask

  task automatic call(input string tag, input logic [31:0] tgt);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tgt, 1'b1, 1'b0, 1'b1, tgt);
  endtask

  task automatic ret(input string tag, input logic exp_flush, input logic [31:0] exp_pc);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, exp_flush, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; exc_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h300;
    jump_i = 1'b0; jump_target_i = 32'h0; call_i = 1'b0; ret_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc", pc_o, 32'h0);
    check("rst.flush", {31'b0, flush_o}, 32'h0);
    check("rst.empty", {31'b0, ras_empty_o}, 32'h1);
    check("rst.ovf", {31'b0, ras_overflow_o}, 32'h0);
    check("rst.unf", {31'b0, ras_underflow_o}, 32'h0);
    branch_taken_i = 1'b0;
    rst_n = 1'b1;

    seq("seq0", 32'h4);
    seq("seq1", 32'h8);
    seq("seq2", 32'hC);
    seq("seq3", 32'h10);

    call("call_a", 32'h400);
    call("call_b", 32'h800);
    ret("ret_b", 1'b1, 32'h404);
    ret("ret_a", 1'b1, 32'h14);
    check("ret.empty", {31'b0, ras_empty_o}, 32'h1);
    ret("ret_under", 1'b0, 32'h18);
    check("under.flag", {31'b0, ras_underflow_o}, 32'h1);
    check("under.empty", {31'b0, ras_empty_o}, 32'h1);

    step("stall_jump", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h18);
    step("stall_br", 1'b1, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);

    step("jmp_top", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap.plus", pc_plus_o, 32'h0);
    seq("wrap", 32'h0);

    call("ovf1", 32'h1000);
    call("ovf2", 32'h2000);
    call("ovf3", 32'h3000);
    call("ovf4", 32'h4000);
    check("full.ovf", {31'b0, ras_overflow_o}, 32'h0);
    call("ovf5", 32'h5000);
    check("ovf.flag", {31'b0, ras_overflow_o}, 32'h1);
    ret("oret5", 1'b1, 32'h4004);
    ret("oret4", 1'b1, 32'h3004);
    ret("oret3", 1'b1, 32'h2004);
    ret("oret2", 1'b1, 32'h1004);
    check("oret.empty", {31'b0, ras_empty_o}, 32'h1);

    call("pre_swap", 32'h6000);
    step("swap", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7000, 1'b1, 1'b1, 1'b1, 32'h1008);
    check("swap.empty", {31'b0, ras_empty_o}, 32'h0);
    ret("swap_ret", 1'b1, 32'h6004);
    check("swap_ret.empty", {31'b0, ras_empty_o}, 32'h1);

    call("exc_c1", 32'h8000);
    call("exc_c2", 32'h9000);
    check("exc.pre_empty", {31'b0, ras_empty_o}, 32'h0);
    step("exc", 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80);
    check("exc.empty", {31'b0, ras_empty_o}, 32'h1);
    check("exc.ovf_sticky", {31'b0, ras_overflow_o}, 32'h1);
    ret("exc_ret", 1'b0, 32'h84);
    step("exc_stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80);

    stall_i = 1'b0; exc_i = 1'b0; ret_i = 1'b0; jump_i = 1'b0; call_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.pc", pc_o, 32'h0);
    check("mid_rst.ovf", {31'b0, ras_overflow_o}, 32'h0);
    check("mid_rst.unf", {31'b0, ras_underflow_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq("post_rst", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the IF stage of the pipelined processor. It holds the PC register and advances it by a fixed step each cycle. It also selects the next PC from exception, branch, return and jump redirects under a fixed priority, and honours pipeline stalls. An internal return-address stack (RAS) predicts subroutine returns. It succeeds the plain combinational PC + 4 adder: width, step and stack depth are configurable, and all next-PC state lives inside the block.

## Interface

- WIDTH, 32, PC and target width in bits
- STEP, 4, sequential increment; power of two, ≥ 1
- RESET_PC, 0, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, exception handler address (truncated to WIDTH)
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2

Ports:

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold PC (pipeline bubble)
- exc_i  in  1  exception request
- branch_taken_i  in  1  resolved taken branch from EX
- branch_target_i  in  WIDTH  branch destination
- jump_i  in  1  unconditional jump decoded in ID
- jump_target_i  in  WIDTH  jump destination
- call_i  in  1  jump is a call (jal); meaningful only with jump_i
- ret_i  in  1  return (jr $ra) decoded in ID
- pc_o  out  WIDTH  current PC (registered)
- pc_plus_o  out  WIDTH  pc_o + STEP (combinational)
- flush_o  out  1  a redirect is accepted this cycle (combinational)
- ras_empty_o  out  1  RAS holds no entries
- ras_overflow_o  out  1  sticky: push occurred while RAS full
- ras_underflow_o  out  1  sticky: ret accepted while RAS empty

## Operation

- Reset (rst_n=0, asynchronous):
  - pc_o = RESET_PC
  - RAS count = 0, write pointer = 0
  - sticky flags = 0; ras_empty_o = 1
  - flush_o is forced 0 while rst_n=0
- Arithmetic:
  - pc_plus_o = (pc_o + STEP) mod 2^WIDTH; wrap-around is silent.
  - All loaded targets have their low log2(STEP) bits forced to zero.
- Next-PC priority, highest first:
  1. exc_i → EXC_VECTOR. Accepted even when stall_i=1. Clears the RAS (count=0). Sticky flags are unchanged.
  2. branch_taken_i → branch_target_i. Accepted even when stall_i=1. RAS unchanged.
  3. ret_i, stall_i=0, RAS non-empty → target is the top entry; pop.
  4. jump_i, stall_i=0 → jump_target_i. If call_i, push pc_plus_o.
  5. stall_i=0 → pc_plus_o.
  6. stall_i=1 → hold pc_o.
- jump_i, call_i and ret_i are ignored while stall_i=1; the ID stage reasserts them.
- ret_i with RAS empty (stall_i=0):
  - no redirect; the PC advances sequentially
  - ras_underflow_o sets
  - flush_o stays 0
- ret_i and jump_i+call_i in the same cycle, RAS non-empty:
  - target is the old top entry
  - the top entry is overwritten with pc_plus_o; count unchanged
  - the jump target is discarded
- RAS is circular:
  - push when count = RAS_DEPTH overwrites the oldest entry and sets ras_overflow_o; count saturates
  - pop decrements count
- flush_o = 1 whenever case 1, 2, 3 or 4 is selected. For case 3 this means the RAS was non-empty.
- Sticky flags clear only on reset.

## Timing

- pc_o updates on the rising clk edge following the cycle in which the selection was made. Redirect latency is 1 cycle: a target presented in cycle N appears on pc_o in cycle N+1.
- flush_o and pc_plus_o are valid in the same cycle as their inputs; no registered delay.
- RAS push/pop and flag updates take effect at the same edge as the PC update.
- Reset asserted mid-operation overrides everything immediately. On rst_n deassertion, the first edge loads RESET_PC + STEP when stall_i=0.

## Test plan

- Reset release, WIDTH=32, RESET_PC=0, no stalls, 4 cycles → pc_o = 0, 4, 8, 12; flush_o = 0 throughout.
- pc_o = 0xFFFF_FFFC with no redirect → next pc_o = 0x0000_0000 (wrap).
- stall_i=1 with jump_i=1 (target 0x100) → pc_o holds, flush_o=0. Then stall_i=1 with branch_taken_i=1 (target 0x203) → pc_o = 0x200 next cycle, flush_o=1.
- Call sequence:
  - jump+call at PC 0x10 → 0x400 (push 0x14)
  - jump+call at PC 0x400 → 0x800 (push 0x404)
  - ret → 0x404
  - ret → 0x14
  - third ret → sequential advance, ras_underflow_o=1, ras_empty_o=1
- RAS_DEPTH=4, five calls without return → ras_overflow_o=1. The next four rets return the 5th, 4th, 3rd and 2nd return addresses.
- exc_i together with branch_taken_i and ret_i, RAS holding 2 entries → pc_o = 0x80 next cycle, ras_empty_o=1, flush_o=1.
